mod100_down_timer: RTL and testbench



---
 rtl/mod100_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 28 ++
 rtl/mod100_down_timer.sv | 162 ++++++++++++++++
 tb/tb_mod100_down_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod100_pkg.sv
// Shared encodings for the mod-100 countdown timer: FSM states, active-low
// seven-segment patterns, anode patterns and a BCD clamp helper.
package mod100_pkg;

    // Timer state encoding. The ST_ prefix keeps these literals from
    // colliding with the DONE output port of the top level.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Active-low cathode patterns, CA[0]=a .. CA[6]=g, CA[7]=dp (dp kept off).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low anode patterns; only the two rightmost digits are used.
    localparam logic [7:0] AN_OFF    = 8'hFF;
    localparam logic [7:0] AN_DIGIT0 = 8'b1111_1110;
    localparam logic [7:0] AN_DIGIT1 = 8'b1111_1101;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Switch nibbles above 9 are not valid BCD; saturate them to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment cathode pattern.
// Non-BCD inputs blank the digit; the counter never produces them.
module seg7_decode
    import mod100_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Digit lookup, blank for anything outside 0..9.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mod100_down_timer.sv
// Loadable two-digit BCD countdown timer (99..00) with run/pause, terminal
// count flag and a multiplexed two-digit seven-segment display. Everything
// runs from CLK; the count tick and the display scan are enables, not clocks.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | value loaded, not counting
// ST_RUN   | prescaler advancing, count decrements on tick
// ST_PAUSE | prescaler and count frozen
// ST_DONE  | count reached 00, only LOAD leaves
module mod100_down_timer
    import mod100_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW,
    input  logic       LOAD,
    input  logic       START,
    output logic       DONE,
    output logic [7:0] AN,
    output logic [7:0] CA
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW_W = $clog2(SCAN_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW_W-1:0] SCAN_LAST = SW_W'(SCAN_DIV - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        tens;
    logic [3:0]        ones;
    logic [TW-1:0]     presc;
    logic              tick;
    logic              cnt_zero;
    logic              cnt_one;
    logic [SW_W-1:0]   scan_cnt;
    logic              scan_tc;
    logic              sel;
    logic [7:0]        seg_ones;
    logic [7:0]        seg_tens;

    assign cnt_zero = (tens == 4'd0) && (ones == 4'd0);
    assign cnt_one  = (tens == 4'd0) && (ones == 4'd1);

    // The tick is only ever raised while running, so PAUSE/DONE/IDLE never count.
    assign tick    = (state == ST_RUN) && (presc == TICK_LAST);
    assign scan_tc = (scan_cnt == SCAN_LAST);

    assign DONE = (state == ST_DONE);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; LOAD overrides START and any pending tick.
    always_comb begin
        state_nxt = state;
        if (LOAD) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state_nxt = cnt_zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Reaching 00 takes priority over a simultaneous pause request.
                    if (tick && cnt_one) begin
                        state_nxt = ST_DONE;
                    end else if (START) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (START) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Tick prescaler: advances in RUN, holds its phase through PAUSE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else if (LOAD) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + TW'(1);
        end
    end

    // BCD count: clamped preload on LOAD, borrow-aware decrement on tick.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (LOAD) begin
            tens <= bcd_clamp(SW[7:4]);
            ones <= bcd_clamp(SW[3:0]);
        end else if (tick && !cnt_zero) begin
            if (ones != 4'd0) begin
                ones <= ones - 4'd1;
            end else begin
                ones <= BCD_MAX;
                tens <= tens - 4'd1;
            end
        end
    end

    seg7_decode u_seg_ones (
        .bcd (ones),
        .seg (seg_ones)
    );

    seg7_decode u_seg_tens (
        .bcd (tens),
        .seg (seg_tens)
    );

    // Free-running scan counter and digit select, unaffected by LOAD/START.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + SW_W'(1);
        end
    end

    // Display outputs registered once per scan slot from the current select.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AN <= AN_OFF;
            CA <= SEG_BLANK;
        end else if (scan_tc) begin
            AN <= sel ? AN_DIGIT1 : AN_DIGIT0;
            CA <= sel ? seg_tens : seg_ones;
        end
    end

endmodule

// File: tb/tb_mod100_down_timer.sv
// Directed self-checking bench for mod100_down_timer with TICK_DIV=4, SCAN_DIV=3.
module tb_mod100_down_timer;
    import mod100_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SW;
    logic       LOAD;
    logic       START;
    logic       DONE;
    logic [7:0] AN;
    logic [7:0] CA;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 CLK = ~CLK;

    mod100_down_timer #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .SW    (SW),
        .LOAD  (LOAD),
        .START (START),
        .DONE  (DONE),
        .AN    (AN),
        .CA    (CA)
    );

    // Edges since reset release; scan updates land where cyc is a multiple of 3.
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] seg_exp(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        SW   = v;
        LOAD = 1'b1;
        step(1);
        LOAD = 1'b0;
    endtask

    task automatic do_start();
        START = 1'b1;
        step(1);
        START = 1'b0;
    endtask

    // At a scan update edge, the display must show the digit of pv picked by the slot parity.
    task automatic disp_check(input int pv);
        if (cyc % 3 == 0) begin
            if ((cyc / 3) % 2 == 1) begin
                check("an_ones", AN, 8'hFE);
                check("ca_ones", CA, seg_exp(pv % 10));
            end else begin
                check("an_tens", AN, 8'hFD);
                check("ca_tens", CA, seg_exp(pv / 10));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        RST = 1'b0; SW = 8'h00; LOAD = 1'b0; START = 1'b0;
        #1 RST = 1'b1;
        #2;
        check("rst_an", AN, 8'hFF);
        check("rst_ca", CA, 8'hFF);
        check("rst_done", DONE, 1'b0);
        check("rst_cnt", {dut.tens, dut.ones}, 8'h00);
        @(posedge CLK); #1;
        RST = 1'b0;
        step(2);
        check("scan_pre_an", AN, 8'hFF);
        step(1);
        check("scan1_an", AN, 8'hFE);
        check("scan1_ca", CA, 8'hC0);

        // Countdown 12 -> 00, one step every 4 edges, with display tracking.
        do_load(8'h12);
        check("ld12_cnt", {dut.tens, dut.ones}, 8'h12);
        check("ld12_done", DONE, 1'b0);
        do_start();
        check("run_state", 32'(dut.state), 32'(ST_RUN));
        for (int k = 1; k <= 48; k++) begin
            int pv;
            pv = 12 - (k - 1) / 4;
            step(1);
            check("cnt_dn", {dut.tens, dut.ones}, bcd(12 - k / 4));
            check("done_dn", DONE, (k == 48));
            disp_check(pv);
        end
        step(4);
        check("hold00_cnt", {dut.tens, dut.ones}, 8'h00);
        check("hold00_done", DONE, 1'b1);

        // Pause at 07 keeps the prescaler phase.
        do_load(8'h08);
        do_start();
        step(4);
        check("p_cnt07", {dut.tens, dut.ones}, 8'h07);
        step(2);
        do_start();
        check("p_state", 32'(dut.state), 32'(ST_PAUSE));
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("p_hold", {dut.tens, dut.ones}, 8'h07);
        end
        do_start();
        check("p_resume_cnt", {dut.tens, dut.ones}, 8'h07);
        check("p_resume_st", 32'(dut.state), 32'(ST_RUN));
        step(1);
        check("p_tick06", {dut.tens, dut.ones}, 8'h06);
        step(3);
        check("p_hold06", {dut.tens, dut.ones}, 8'h06);
        step(1);
        check("p_tick05", {dut.tens, dut.ones}, 8'h05);

        // LOAD and START together during RUN: LOAD wins.
        SW = 8'h45; LOAD = 1'b1; START = 1'b1;
        step(1);
        LOAD = 1'b0; START = 1'b0;
        check("ls_cnt", {dut.tens, dut.ones}, 8'h45);
        check("ls_state", 32'(dut.state), 32'(ST_IDLE));
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("ls_hold", {dut.tens, dut.ones}, 8'h45);
        end

        // Edge loads.
        do_load(8'hAF);
        check("clamp99", {dut.tens, dut.ones}, 8'h99);
        do_load(8'h00);
        check("ld00_cnt", {dut.tens, dut.ones}, 8'h00);
        check("ld00_done", DONE, 1'b0);
        do_start();
        check("st00_done", DONE, 1'b1);
        check("st00_cnt", {dut.tens, dut.ones}, 8'h00);
        step(8);
        check("d_hold_done", DONE, 1'b1);
        check("d_hold_cnt", {dut.tens, dut.ones}, 8'h00);
        do_start();
        check("d_start_done", DONE, 1'b1);
        check("d_start_st", 32'(dut.state), 32'(ST_DONE));
        step(5);
        check("d_start_cnt", {dut.tens, dut.ones}, 8'h00);

        // Scan alternation with count 37.
        do_load(8'h37);
        step(1);
        w = 0;
        while (cyc % 6 != 3 && w < 6) begin
            step(1);
            w++;
        end
        check("scan_sync", cyc % 6, 3);
        check("s37_an0", AN, 8'hFE);
        check("s37_ca0", CA, 8'hF8);
        step(1);
        check("s37_an_hold", AN, 8'hFE);
        step(2);
        check("s37_an1", AN, 8'hFD);
        check("s37_ca1", CA, 8'hB0);
        check("s37_hi1", AN[7:2], 6'h3F);
        step(3);
        check("s37_an2", AN, 8'hFE);
        check("s37_ca2", CA, 8'hF8);
        check("s37_hi2", AN[7:2], 6'h3F);
        step(3);
        check("s37_an3", AN, 8'hFD);
        check("s37_ca3", CA, 8'hB0);

        // Asynchronous reset in the middle of a run.
        do_load(8'h20);
        do_start();
        step(6);
        check("mr_cnt19", {dut.tens, dut.ones}, 8'h19);
        RST = 1'b1;
        #2;
        check("mr_an", AN, 8'hFF);
        check("mr_ca", CA, 8'hFF);
        check("mr_done", DONE, 1'b0);
        check("mr_cnt", {dut.tens, dut.ones}, 8'h00);
        @(posedge CLK); #1;
        RST = 1'b0;
        step(2);
        check("mr_pre_an", AN, 8'hFF);
        step(1);
        check("mr_scan_an", AN, 8'hFE);
        check("mr_scan_ca", CA, 8'hC0);
        step(8);
        check("mr_idle_cnt", {dut.tens, dut.ones}, 8'h00);
        check("mr_idle_st", 32'(dut.state), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
